// File: rtl/spi_sram_arbiter.sv
// Two-port arbiter in front of a serial SPI SRAM: round-robin grant, one
// 64-bit mode-0 frame per access (opcode, 24-bit address, 32 data bits).
module spi_sram_arbiter #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic [23:0] p0_addr,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        sram_ce,
  output logic        sclk,
  output logic        si,
  input  logic        so,
  output logic        busy
);

  // Handshake: a port raises req (with address/data) and may drop it once the
  // request has been sampled in IDLE; completion is a single-cycle ack, with
  // read data valid in that same cycle.

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, END} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic        grant;
  logic        last;
  logic        we_q;
  logic [63:0] frame;
  logic [31:0] rx;

  logic        pick_p1;
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [63:0] frame_nxt;

  // Data travels little-endian by byte; each byte itself goes MSB-first.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // A lone request wins directly; a tie goes to the port not served last.
  assign pick_p1   = p1_req & (~p0_req | ~last);
  assign sel_we    = pick_p1 & p1_we;
  assign sel_addr  = pick_p1 ? p1_addr : p0_addr;
  assign frame_nxt = {(sel_we ? CMD_WRITE : CMD_READ), sel_addr,
                      (sel_we ? swap_bytes(p1_wdata) : 32'h0)};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p0_req || p1_req) state_nxt = SETUP;
      SETUP:   state_nxt = SHIFT;
      SHIFT:   if (cnt == 7'd127) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 7'd0;
      grant    <= 1'b0;
      last     <= 1'b1;
      we_q     <= 1'b0;
      frame    <= 64'h0;
      rx       <= 32'h0;
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant <= pick_p1;
            last  <= pick_p1;
            we_q  <= sel_we;
            frame <= frame_nxt;
            cnt   <= 7'd0;
          end
        end
        SHIFT: begin
          cnt <= cnt + 7'd1;
          // Even cycles are sclk-high; their closing edge is the sclk fall.
          if (!cnt[0]) begin
            frame <= {frame[62:0], 1'b0};
            rx    <= {rx[30:0], so};
          end
          if (cnt == 7'd127 && !we_q) begin
            if (grant) p1_rdata <= swap_bytes(rx);
            else       p0_rdata <= swap_bytes(rx);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign sram_ce = ~((state == SETUP) || (state == SHIFT));
  assign sclk    = (state == SHIFT) & ~cnt[0];
  assign si      = ((state == SETUP) || (state == SHIFT)) & frame[63];
  assign p0_ack  = (state == END) & ~grant;
  assign p1_ack  = (state == END) & grant;

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Bench for spi_sram_arbiter: vector table, hand-written corner sequences and
// random traffic, all checked every cycle against a cycle-count reference model.
module tb_spi_sram_arbiter;

  localparam logic [7:0] OP_RD = 8'h03;
  localparam logic [7:0] OP_WR = 8'h02;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr;
  logic [31:0] p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_ce, sclk, si, so, busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  spi_sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_ce(sram_ce), .sclk(sclk), .si(si), .so(so), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memories (reference and SRAM model) ----------------
  logic [7:0] ref_mem  [logic [23:0]];
  logic [7:0] sram_mem [logic [23:0]];

  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a[7:0] ^ 8'h5A);
  endfunction
  function automatic logic [7:0] sram_byte(input logic [23:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  // ---------------- reference model + SRAM model + scoreboard ----------------
  logic [63:0] exp_q[$];
  bit          m_active;
  bit          m_last;
  bit          m_port;
  bit          m_we;
  int          m_g;
  logic [23:0] m_addr;
  logic [31:0] m_wd, m_rd;
  logic [31:0] exp_p0_rd, exp_p1_rd;
  int          off, k, j;
  logic [63:0] cap, ef;
  logic [23:0] s_addr;
  logic [7:0]  b;
  bit          prev_ce;
  logic        e_busy, e_ce, e_sclk, e_a0, e_a1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_last = 1; exp_p0_rd = 0; exp_p1_rd = 0;
      exp_q.delete(); k = 0; prev_ce = 1; so = 1'b0;
      chk("reset_ctrl", {busy, sram_ce, sclk, si, p0_ack, p1_ack}, 6'b010000);
      chk("reset_rdata", {p0_rdata, p1_rdata}, 64'h0);
    end else begin
      // what the outputs must be in this cycle, from the transfer timeline
      off = m_active ? (cyc - m_g) : 0;
      e_busy = m_active && off >= 1;
      e_ce   = !(m_active && off >= 1 && off <= 129);
      e_sclk = m_active && off >= 2 && off <= 129 && ((off - 2) % 2 == 0);
      e_a0   = m_active && off == 130 && !m_port;
      e_a1   = m_active && off == 130 && m_port;
      if (m_active && off == 130) begin
        if (!m_port) exp_p0_rd = m_rd;
        else if (!m_we) exp_p1_rd = m_rd;
        else for (int i = 0; i < 4; i++) ref_mem[m_addr + 24'(i)] = m_wd[8*i +: 8];
      end
      chk("ctrl{busy,ce,sclk,ack0,ack1}", {busy, sram_ce, sclk, p0_ack, p1_ack},
          {e_busy, e_ce, e_sclk, e_a0, e_a1});
      chk("p0_rdata", p0_rdata, exp_p0_rd);
      chk("p1_rdata", p1_rdata, exp_p1_rd);
      if (!e_busy) chk("si_idle", si, 1'b0);

      // SPI SRAM: takes si on sclk rise, presents read data for the next fall
      if (!sram_ce) begin
        if (sclk) begin
          cap = {cap[62:0], si};
          if (k == 31) s_addr = cap[23:0];
          if (k >= 32) begin
            j = k - 32;
            b = sram_byte(s_addr + 24'(j / 8));
            so = b[7 - (j % 8)];
          end
          k++;
        end
      end else if (!prev_ce) begin
        chk("sclk_rises_per_frame", k, 64);
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          ef = exp_q.pop_front();
          chk("si_frame", cap, ef);
        end
        if (k == 64 && cap[63:56] == OP_WR)
          for (int i = 0; i < 4; i++) sram_mem[cap[55:32] + 24'(i)] = cap[31 - 8*i -: 8];
        k = 0; so = 1'b0;
      end
      prev_ce = sram_ce;

      // grant decisions happen only in idle cycles
      if (m_active && off >= 130) m_active = 0;
      else if (!m_active && (p0_req || p1_req)) begin
        m_port = (p0_req && p1_req) ? !m_last : p1_req;
        m_last = m_port;
        m_we   = m_port && p1_we;
        m_addr = m_port ? p1_addr : p0_addr;
        m_wd   = p1_wdata;
        m_rd   = {ref_byte(m_addr + 24'd3), ref_byte(m_addr + 24'd2),
                  ref_byte(m_addr + 24'd1), ref_byte(m_addr)};
        exp_q.push_back({m_we ? OP_WR : OP_RD, m_addr,
                         m_we ? {m_wd[7:0], m_wd[15:8], m_wd[23:16], m_wd[31:24]} : 32'h0});
        m_g = cyc;
        m_active = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        r0, r1, we, pulse;
    logic [23:0] a0, a1;
    logic [31:0] wd;
    int          exp_port;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic clear_inputs();
    p0_req = 0; p1_req = 0; p1_we = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0; clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int t0, got, ack_cyc;
    logic [31:0] rd;
    got = -1; ack_cyc = 0; rd = 0;
    @(posedge clk); #1;
    p0_req = v.r0; p1_req = v.r1; p1_we = v.we;
    p0_addr = v.a0; p1_addr = v.a1; p1_wdata = v.wd;
    t0 = cyc;
    if (v.pulse) begin @(posedge clk); #1 clear_inputs(); end
    for (int i = 0; i < 300 && got < 0; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        got = p1_ack ? 1 : 0; ack_cyc = cyc; rd = p1_ack ? p1_rdata : p0_rdata;
      end
    end
    chk({name, "_ack_seen"}, got >= 0, 1);
    chk({name, "_port"}, got, v.exp_port);
    chk({name, "_latency"}, ack_cyc - t0, 130);
    if (!(v.we && v.exp_port == 1)) chk({name, "_rdata"}, rd, v.exp_rd);
    @(posedge clk); #1 clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order[4];
    int n_ack, acks;
    rst_n = 0; clear_inputs(); p0_addr = 0; p1_addr = 0; p1_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[24'h10 + 24'(i)]  = 8'h11 * 8'(i + 1);
      sram_mem[24'h10 + 24'(i)] = 8'h11 * 8'(i + 1);
    end
    vecs[0] = '{1, 0, 0, 0, 24'h000010, 24'h0,      32'h0,        0, 32'h44332211};
    vecs[1] = '{0, 1, 1, 0, 24'h0,      24'h123456, 32'hDEADBEEF, 1, 32'h0};
    vecs[2] = '{0, 1, 0, 1, 24'h0,      24'h123456, 32'h0,        1, 32'hDEADBEEF};
    vecs[3] = '{1, 0, 0, 0, 24'h123454, 24'h0,      32'h0,        0, 32'hBEEF0F0E};
    vecs[4] = '{1, 1, 0, 0, 24'h000020, 24'h000010, 32'h0,        1, 32'h44332211};
    vecs[5] = '{1, 1, 1, 0, 24'h000000, 24'h000040, 32'h12345678, 0, 32'h59585B5A};
    vecs[6] = '{0, 1, 1, 1, 24'h0,      24'hFFFFFE, 32'h01020304, 1, 32'h0};
    vecs[7] = '{1, 0, 0, 0, 24'hFFFFFE, 24'h0,      32'h0,        0, 32'h01020304};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // both ports held from reset: alternate starting with port 0
    do_reset();
    @(posedge clk); #1;
    p0_req = 1; p1_req = 1; p1_we = 0; p0_addr = 24'h000100; p1_addr = 24'h000200;
    n_ack = 0;
    for (int i = 0; i < 700 && n_ack < 4; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin order[n_ack] = p1_ack ? 1 : 0; n_ack++; end
    end
    @(posedge clk); #1 clear_inputs();
    chk("rr_ack_count", n_ack, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);

    // reset in the middle of a shift: no ack, then a clean fresh transfer
    @(posedge clk); #1 p0_req = 1; p0_addr = 24'h000010;
    @(posedge clk); #1 p0_req = 0;
    repeat (40) @(posedge clk);
    @(negedge clk) chk("mid_shift_busy_ce", {busy, sram_ce}, 2'b10);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk) chk("abort_ce_sclk", {sram_ce, sclk, p0_ack}, 3'b100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    acks = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    chk("no_ack_after_abort", acks, 0);
    run_vec("post_reset_read", '{0, 1, 0, 0, 24'h0, 24'h123456, 32'h0, 1, 32'hDEADBEEF});

    // random traffic with requests arriving at arbitrary times
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      p0_req = 1'($urandom_range(0, 1));
      p1_req = 1'($urandom_range(0, 1));
      p1_we  = 1'($urandom_range(0, 1));
      p0_addr = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 63));
      p1_addr = 24'($urandom_range(0, 63));
      p1_wdata = $urandom;
      repeat ($urandom_range(1, 200)) @(posedge clk);
    end
    #1 clear_inputs();
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("frames_pending", exp_q.size(), 0);
    chk("drained_idle", {busy, sram_ce}, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
